// File: rtl/regfile_arbiter.sv
// Two-master round-robin req/ack arbiter for the register file write port and read port A.
// Optional macro R0_PROTECT_EN: writes to address 0 are acknowledged but never committed.
module regfile_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;
    logic              gnt_q, gnt_d;

    logic              pick;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              wr_blk;

    // Under contention the requester not served last wins.
    assign pick      = (req0 && req1) ? ~last_q : req1;
    assign we_sel    = pick ? we1 : we0;
    assign addr_sel  = pick ? addr1 : addr0;
    assign wdata_sel = pick ? wdata1 : wdata0;

`ifdef R0_PROTECT_EN
    assign wr_blk = (addr_sel == '0);
`else
    assign wr_blk = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        last_d     = last_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_raddr_d = rf_raddr_q;
        gnt_d      = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    id_d       = pick;
                    we_d       = we_sel;
                    rf_we_d    = we_sel && !wr_blk;
                    rf_waddr_d = addr_sel;
                    rf_raddr_d = addr_sel;
                    rf_wdata_d = wdata_sel;
                    gnt_d      = pick;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (id_q) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = rf_rdata;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = rf_rdata;
                end
                last_d  = id_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            last_q     <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_raddr_q <= '0;
            gnt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            last_q     <= last_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_raddr_q <= rf_raddr_d;
            gnt_q      <= gnt_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_raddr = rf_raddr_q;
    assign busy     = (state_q != IDLE);
    assign gnt_id   = gnt_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural 32x32 register file.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req0, we0, req1, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        rf_we;
    logic [4:0]  rf_waddr, rf_raddr;
    logic [31:0] rf_wdata, rf_rdata;
    logic        busy, gnt_id;

    logic [31:0] mem [32];

    typedef struct packed {
        logic        id;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    always @(posedge clk) if (rf_we) mem[rf_waddr] <= rf_wdata;
    assign rf_rdata = mem[rf_raddr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ack0 && ack1) begin
            chk("ack_exclusive", 32'({ack0, ack1}), 32'd1);
        end else if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'({ack0, ack1}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_id", 32'(ack1), 32'(e.id));
                chk("gnt_id", 32'(gnt_id), 32'(e.id));
                if (e.rd) chk("rdata", ack1 ? rdata1 : rdata0, e.data);
            end
        end
    end

    task automatic txn(input bit m, input bit we, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
        bit seen;
        int nwe;
        int exp_we;
        exp_we = we ? 1 : 0;
`ifdef R0_PROTECT_EN
        if (a == 5'd0) exp_we = 0;
`endif
        sb.push_back({m, !we, exp_rd});
        if (m) begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end
        seen = 0;
        nwe  = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (rf_we) begin
                nwe++;
                chk("rf_waddr", 32'(rf_waddr), 32'(a));
                chk("rf_wdata", rf_wdata, d);
            end
            if (k == 1) begin
                chk("busy_access", 32'(busy), 32'd1);
                if (!we) chk("rf_raddr", 32'(rf_raddr), 32'(a));
            end
            if (m ? ack1 : ack0) begin
                seen = 1;
                chk("ack_latency", k, 32'd2);
            end
        end
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
        chk("rf_we_cycles", nwe, exp_we);
        if (m) req1 = 1'b0;
        else   req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc, last, n0, n1;
        Reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);

        txn(0, 1, 5'd5, 32'hDEADBEEF, 32'h0);
        txn(1, 0, 5'd5, 32'h0, 32'hDEADBEEF);
        chk("rdata0_held", rdata0, 32'h0);

        sb.push_back({1'b0, 1'b0, 32'h0});
        sb.push_back({1'b1, 1'b0, 32'h0});
        sb.push_back({1'b0, 1'b0, 32'h0});
        sb.push_back({1'b1, 1'b0, 32'h0});
        we0 = 1; addr0 = 5'd10; wdata0 = 32'hA0A0_0001; req0 = 1;
        we1 = 1; addr1 = 5'd11; wdata1 = 32'hB1B1_0002; req1 = 1;
        cyc = 0; last = -1; n0 = 0; n1 = 0;
        while (n0 + n1 < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                if (last >= 0) chk("ack_interval", cyc - last, 32'd3);
                last = cyc;
            end
            if (ack0) begin
                n0++;
                if (n0 == 1) begin addr0 = 5'd12; wdata0 = 32'hC2C2_0003; end
                else req0 = 0;
            end
            if (ack1) begin
                n1++;
                if (n1 == 1) begin addr1 = 5'd13; wdata1 = 32'hD3D3_0004; end
                else req1 = 0;
            end
        end
        chk("contention_done", n0 + n1, 32'd4);
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
        txn(0, 0, 5'd11, 32'h0, 32'hB1B1_0002);
        txn(1, 0, 5'd12, 32'h0, 32'hC2C2_0003);
        txn(1, 0, 5'd13, 32'h0, 32'hD3D3_0004);
        txn(0, 0, 5'd10, 32'h0, 32'hA0A0_0001);
        chk("rdata1_held", rdata1, 32'hD3D3_0004);

        we0 = 1; addr0 = 5'd7; wdata0 = 32'h7777_7777; req0 = 1;
        @(posedge clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("rstmid_rf_we", 32'(rf_we), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ack0", 32'(ack0), 32'd0);
        @(negedge clk);
        req0 = 0;
        Reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_mem7", mem[7], 32'h0);
        txn(1, 0, 5'd7, 32'h0, 32'h0);

        txn(0, 1, 5'd0, 32'h1234_5678, 32'h0);
`ifdef R0_PROTECT_EN
        txn(0, 0, 5'd0, 32'h0, 32'h0);
`else
        txn(0, 0, 5'd0, 32'h0, 32'h1234_5678);
`endif
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
